// File: rtl/capture_ctrl_if.sv
// Signal bundle between the capture sequencer, the ADC front end, the sample RAM and the display path.
// The slave modport is the sequencer's view; the master modport is its surroundings.
interface capture_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] i_sample;
    logic                  i_sample_valid;
    logic                  i_arm;
    logic                  i_force_trig;
    logic [DATA_WIDTH-1:0] i_trig_level;
    logic                  i_trig_rising;
    logic [ADDR_WIDTH-1:0] i_pretrig;
    logic [ADDR_WIDTH-1:0] o_ram_waddr;
    logic [DATA_WIDTH-1:0] o_ram_wdata;
    logic [ADDR_WIDTH-1:0] o_ram_raddr;
    logic [DATA_WIDTH-1:0] i_ram_rdata;
    logic                  i_rd_req;
    logic [ADDR_WIDTH-1:0] i_rd_idx;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_rd_valid;
    logic                  o_busy;
    logic                  o_done;
    logic [ADDR_WIDTH-1:0] o_trig_addr;
    logic [ADDR_WIDTH-1:0] o_start_addr;

    modport slave (
        input  i_sample, i_sample_valid, i_arm, i_force_trig, i_trig_level, i_trig_rising,
               i_pretrig, i_ram_rdata, i_rd_req, i_rd_idx,
        output o_ram_waddr, o_ram_wdata, o_ram_raddr, o_rd_data, o_rd_valid,
               o_busy, o_done, o_trig_addr, o_start_addr
    );

    modport master (
        output i_sample, i_sample_valid, i_arm, i_force_trig, i_trig_level, i_trig_rising,
               i_pretrig, i_ram_rdata, i_rd_req, i_rd_idx,
        input  o_ram_waddr, o_ram_wdata, o_ram_raddr, o_rd_data, o_rd_valid,
               o_busy, o_done, o_trig_addr, o_start_addr
    );
endinterface

// File: rtl/capture_ctrl.sv
// Oscilloscope acquisition sequencer: circular-buffer capture around a level trigger,
// then indexed frame reads translated to RAM addresses.
module capture_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input logic           i_clk,
    input logic           i_rst_n,
    capture_ctrl_if.slave bus
);
    localparam int CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, PREFILL, ARMED, POST, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wp;
    logic [ADDR_WIDTH-1:0] pretrig_q;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] prev;
    logic                  prev_vld;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [ADDR_WIDTH-1:0] trig_addr;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic                  vld_p0;
    logic                  vld_p1;
    logic                  capturing;
    logic                  trig_hit;
    logic [CNT_W-1:0]      post_len;

    function automatic logic edge_hit(input logic [DATA_WIDTH-1:0] prv,
                                      input logic [DATA_WIDTH-1:0] cur,
                                      input logic [DATA_WIDTH-1:0] lvl,
                                      input logic                  rising);
        if (rising) return (prv < lvl) && (cur >= lvl);
        return (prv > lvl) && (cur <= lvl);
    endfunction

    assign capturing = (state == PREFILL) || (state == ARMED) || (state == POST);
    assign trig_hit  = bus.i_force_trig ||
                       (prev_vld && edge_hit(prev, bus.i_sample, bus.i_trig_level, bus.i_trig_rising));
    // Post-trigger length includes the trigger sample; pretrig = 0 gives a whole DEPTH frame.
    assign post_len  = CNT_W'(DEPTH) - {1'b0, pretrig_q};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            wp         <= '0;
            pretrig_q  <= '0;
            cnt        <= '0;
            prev       <= '0;
            prev_vld   <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            raddr      <= '0;
            trig_addr  <= '0;
            start_addr <= '0;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
        end else if (bus.i_arm) begin
            pretrig_q <= bus.i_pretrig;
            wp        <= '0;
            cnt       <= '0;
            prev_vld  <= 1'b0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            state     <= (bus.i_pretrig == '0) ? ARMED : PREFILL;
        end else begin
            // read pipeline: p0 tracks raddr, p1 tracks the RAM output
            vld_p0 <= 1'b0;
            vld_p1 <= vld_p0;

            // Outside capture the write port holds, so the RAM rewrites the same word.
            if (capturing && bus.i_sample_valid) begin
                waddr    <= wp;
                wdata    <= bus.i_sample;
                wp       <= wp + 1'b1;
                prev     <= bus.i_sample;
                prev_vld <= 1'b1;
            end

            case (state)
                PREFILL: begin
                    if (bus.i_sample_valid) begin
                        if (cnt + 1'b1 == {1'b0, pretrig_q}) begin
                            state <= ARMED;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (bus.i_sample_valid && trig_hit) begin
                        trig_addr  <= wp;
                        start_addr <= wp - pretrig_q;
                        cnt        <= CNT_W'(1);
                        state      <= (post_len == CNT_W'(1)) ? DONE : POST;
                    end
                end
                POST: begin
                    if (bus.i_sample_valid) begin
                        if (cnt + 1'b1 == post_len) state <= DONE;
                        else                        cnt   <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.i_rd_req) begin
                        raddr  <= start_addr + bus.i_rd_idx;
                        vld_p0 <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ram_waddr  = waddr;
    assign bus.o_ram_wdata  = wdata;
    assign bus.o_ram_raddr  = raddr;
    assign bus.o_rd_data    = bus.i_ram_rdata;
    assign bus.o_rd_valid   = vld_p1;
    assign bus.o_busy       = capturing;
    assign bus.o_done       = (state == DONE);
    assign bus.o_trig_addr  = trig_addr;
    assign bus.o_start_addr = start_addr;
endmodule
